// File: rtl/fan_ctrl_pkg.sv
// Shared controller package: FSM state encodings and a parameter-sizing helper
// used by the multiplier, PWM and controller blocks.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mul_state_e;

    // Bits needed to hold 0..v-1; never less than 1 so a counter always exists.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        if (v > 1) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (((v - 1) >> i) != 0) r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Enable divider: while en_i is high, emits a tick every DIV clocks.
module clk_div_tick
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/seq_mul_sat.sv
// Sequential signed shift-add multiplier with fixed-point scaling and
// optional saturation of the WIDTH-bit result.
module seq_mul_sat
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned FRAC    = 0,
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned SAT     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] p_o,
    output logic             ovf_o
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned SW = clog2_min1(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);
    localparam logic signed [AW-1:0] MAX_V = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    mul_state_e state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic [AW-1:0]    addend;
    logic signed [AW-1:0] scaled;
    logic             out_of_range;

    clk_div_tick #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (start_i),
        .en_i   (state_q == ST_RUN),
        .tick_o (tick)
    );

    // Arithmetic shift floors the product; range check is on the full-width value.
    always_comb begin
        scaled       = $signed(acc_q) >>> FRAC;
        out_of_range = (scaled > MAX_V) || (scaled < MIN_V);
        addend       = b_q[0] ? a_q : '0;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        if (start_i) begin
            state_d = ST_RUN;
            a_d     = {{WIDTH{a_i[WIDTH-1]}}, a_i};
            b_d     = b_i;
            acc_d   = '0;
            step_d  = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        // The sign bit of b carries negative weight.
                        acc_d  = (step_q == LAST_STEP) ? acc_q - addend : acc_q + addend;
                        a_d    = a_q << 1;
                        b_d    = b_q >> 1;
                        step_d = step_q + SW'(1);
                        if (step_q == LAST_STEP) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ovf_d   = out_of_range;
                    if (out_of_range && (SAT != 0)) begin
                        p_d = scaled[AW-1] ? MIN_V[WIDTH-1:0] : MAX_V[WIDTH-1:0];
                    end else begin
                        p_d = scaled[WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign p_o    = p_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_mul_sat.sv
// Bench for seq_mul_sat: four configurations driven with directed vectors;
// expected results are queued at issue time and matched by a monitor on done_o.
module tb_seq_mul_sat;

    typedef struct {
        logic [7:0] p;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       start_s [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       ovf_w   [4];
    logic [7:0] p_w     [4];

    exp_t sb [4][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mul_sat #(.WIDTH(8), .FRAC(0), .CLK_DIV(1), .SAT(1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .a_i(a_s), .b_i(b_s),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .p_o(p_w[0]), .ovf_o(ovf_w[0]));
    seq_mul_sat #(.WIDTH(8), .FRAC(0), .CLK_DIV(1), .SAT(0)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .a_i(a_s), .b_i(b_s),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .p_o(p_w[1]), .ovf_o(ovf_w[1]));
    seq_mul_sat #(.WIDTH(8), .FRAC(4), .CLK_DIV(1), .SAT(1)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .a_i(a_s), .b_i(b_s),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .p_o(p_w[2]), .ovf_o(ovf_w[2]));
    seq_mul_sat #(.WIDTH(8), .FRAC(0), .CLK_DIV(3), .SAT(1)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[3]), .a_i(a_s), .b_i(b_s),
        .busy_o(busy_w[3]), .done_o(done_w[3]), .p_o(p_w[3]), .ovf_o(ovf_w[3]));

    function automatic int lat_of(input int idx);
        return (idx == 3) ? 25 : 9;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; leaves at the following negedge with start dropped.
    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic push, input logic [7:0] ep, input logic eo);
        exp_t e;
        a_s = a;
        b_s = b;
        start_s[idx] = 1'b1;
        if (push) begin
            e.p   = ep;
            e.ovf = eo;
            e.cyc = cyc + 1 + lat_of(idx);
            sb[idx].push_back(e);
        end
        @(negedge clk);
        start_s[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx);
        int i;
        for (i = 0; i < 200; i++) begin
            if (sb[idx].size() == 0) break;
            @(negedge clk);
        end
        if (sb[idx].size() != 0) begin
            chk("wait_done_timeout", sb[idx].size(), 0);
            sb[idx].delete();
        end
    endtask

    task automatic run(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ep, input logic eo);
        issue(idx, a, b, 1'b1, ep, eo);
        wait_idle(idx);
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < 4; i++) start_s[i] = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (done_w[g]) begin
                        if (sb[g].size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = sb[g].pop_front();
                            chk("result_p", int'(p_w[g]), int'(e.p));
                            chk("result_ovf", int'(ovf_w[g]), int'(e.ovf));
                            chk("done_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("reset_p", int'(p_w[g]), 0);
            chk("reset_ovf", int'(ovf_w[g]), 0);
            chk("reset_busy", int'(busy_w[g]), 0);
            chk("reset_done", int'(done_w[g]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Saturating, integer
        run(0, 8'h05, 8'hFD, 8'hF1, 1'b0);
        run(0, 8'h80, 8'h80, 8'h7F, 1'b1);
        run(0, 8'h7F, 8'h7F, 8'h7F, 1'b1);
        run(0, 8'h80, 8'h7F, 8'h80, 1'b1);
        run(0, 8'hFF, 8'hFF, 8'h01, 1'b0);
        run(0, 8'h00, 8'h5A, 8'h00, 1'b0);
        run(0, 8'h0B, 8'h0B, 8'h79, 1'b0);
        run(0, 8'hF0, 8'h08, 8'h80, 1'b0);

        // Wrapping
        run(1, 8'h80, 8'h80, 8'h00, 1'b1);
        run(1, 8'h7F, 8'h7F, 8'h01, 1'b1);
        run(1, 8'hFB, 8'h03, 8'hF1, 1'b0);

        // Q4 fixed point
        run(2, 8'h18, 8'h28, 8'h3C, 1'b0);
        run(2, 8'hFF, 8'h01, 8'hFF, 1'b0);
        run(2, 8'h7F, 8'h7F, 8'h7F, 1'b1);
        run(2, 8'h80, 8'h10, 8'h80, 1'b0);
        run(2, 8'h01, 8'h07, 8'h00, 1'b0);
        run(2, 8'hF9, 8'h01, 8'hFF, 1'b0);

        // Divided clock: busy span
        issue(3, 8'h07, 8'h09, 1'b1, 8'h3F, 1'b0);
        busy_cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_w[3]) break;
            busy_cnt++;
        end
        chk("div3_busy_cycles", busy_cnt, 25);
        wait_idle(3);
        run(3, 8'hFE, 8'h03, 8'hFA, 1'b0);

        // Restart mid-run discards the first multiply
        issue(0, 8'h64, 8'h64, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        issue(0, 8'h02, 8'h03, 1'b1, 8'h06, 1'b0);
        wait_idle(0);
        @(negedge clk);

        // Start in the same cycle as done_o
        issue(0, 8'h03, 8'h04, 1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (done_w[0]) break;
            @(negedge clk);
        end
        chk("b2b_done_seen", int'(done_w[0]), 1);
        issue(0, 8'hF9, 8'h06, 1'b1, 8'hD6, 1'b0);
        wait_idle(0);
        @(negedge clk);

        // Reset landing in FINISH
        issue(0, 8'h05, 8'hFD, 1'b0, 8'h00, 1'b0);
        repeat (8) @(negedge clk);
        chk("finish_busy", int'(busy_w[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_finish_p", int'(p_w[0]), 0);
        chk("rst_finish_ovf", int'(ovf_w[0]), 0);
        chk("rst_finish_busy", int'(busy_w[0]), 0);
        chk("rst_finish_done", int'(done_w[0]), 0);

        repeat (30) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            if (sb[g].size() != 0) chk("leftover_expected", sb[g].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
